ucode_fetch: RTL and testbench
==============================

Name: ucode_fetch

Overview:
- Microcode instruction fetch stage: reads 128-bit instruction words from the microcode SRAM and buffers them in a small prefetch FIFO.
- Presents each word to the downstream decoder/sequencer over a valid/ready interface; the decoder uses the shared ISA field layout.
- Fetch starts at a programmed base PC and stops after an OP_END word has been fetched and accepted downstream.
- Sits between the ucode SRAM (loaded by DMA_UCODE) and the instruction decoder.

Parameters:
- ADDR_W, 10: ucode SRAM word-address width; depth = 2**ADDR_W.
- FIFO_DEPTH, 4: prefetch FIFO entries; power of two, >= 2.
- INSTR_W, 128: instruction width; must equal the ISA instruction width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins fetch at base_pc; ignored while busy.
- base_pc  in  ADDR_W  first word address, sampled on an accepted start.
- abort  in  1  synchronous flush to IDLE; no done pulse.
- busy  out  1  high from the cycle after an accepted start until done, or until the cycle after abort.
- done  out  1  one-cycle pulse when program fetch completes.
- err_wrap  out  1  sticky; PC reached the last address without OP_END; cleared by an accepted start.
- mem_rd_en  out  1  SRAM read strobe.
- mem_rd_addr  out  ADDR_W  SRAM read address.
- mem_rd_data  in  INSTR_W  SRAM data, valid exactly 1 cycle after mem_rd_en.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decoder accepts head.
- instr_data  out  INSTR_W  FIFO head word.
- instr_pc  out  ADDR_W  address of head word.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; pc = 0; in-flight flag = 0.
- FSM states:
  - IDLE: an accepted start moves to FETCH, loads pc <= base_pc and clears err_wrap.
  - FETCH: issues reads; moves to DRAIN on the stop condition.
  - DRAIN: no new reads; moves to DONE when the FIFO is empty, there is no in-flight read, and the last handshake has occurred.
  - DONE: done = 1 for one cycle, then IDLE.
- Read issue (FETCH only): mem_rd_en = 1 when fifo_count + inflight < FIFO_DEPTH.
  - Issued address is pc; pc increments on each issue.
  - Maximum one read in flight; throughput is 1 word/cycle when downstream is always ready.
- Read return: the cycle after mem_rd_en, {mem_rd_data, issue address} is pushed into the FIFO.
  - The credit rule guarantees no overflow; a push into a full FIFO is a design error and must be asserted in simulation.
- Stop conditions:
  - Returned opcode (bits [7:0]) == 255 (OP_END): the word is enqueued. The read issued in the same cycle, if any, is discarded on return and not enqueued. FSM goes to DRAIN.
  - Issue of address 2**ADDR_W-1: no wrap to 0. If that word is not OP_END, set err_wrap and go to DRAIN.
- Downstream handshake: a word transfers when instr_valid && instr_ready.
  - instr_data and instr_pc are stable while instr_valid && !instr_ready.
  - Simultaneous push and pop with fifo_count unchanged is legal.
- Latency: instr_valid rises 2 cycles after an accepted start (issue cycle, then return cycle, then registered FIFO head). FIFO output is registered; there is no combinational path from mem_rd_data to instr_data.
- Done: done pulses the cycle after the OP_END handshake, or after the FIFO drains on err_wrap. busy falls in the same cycle done pulses.
- Abort (any state, priority over all else): FIFO cleared, in-flight return discarded, FSM to IDLE, instr_valid = 0 next cycle, done not pulsed, err_wrap kept.
- start and abort in the same cycle: abort wins; start is ignored.
- start while busy: ignored; no state change.
- Asynchronous reset mid-fetch: all state is cleared immediately; the in-flight SRAM return is ignored.

Optional Feature:
- Macro UCODE_FETCH_NOP_SKIP_EN.
  - Defined: returned words with opcode 0 (OP_NOP) are dropped and not enqueued; credit is released, so fetch continues. Stop-condition logic is unaffected.
  - Undefined: NOPs are forwarded like any other word.

Decomposition:
- Shared package: fetch FSM enum (FS_IDLE, FS_FETCH, FS_DRAIN, FS_DONE), UCODE_ADDR_W default constant. Reuse the existing opcode enum and instruction-width constant.
- Natural sub-module: ucode_fetch_fifo.
  - Synchronous FIFO with registered output, width INSTR_W+ADDR_W, depth FIFO_DEPTH.
  - Outputs count/full/empty; provides simultaneous push/pop.

Test Plan:
- Program at base_pc=0x010: NOP, GEMM, VEC, END; instr_ready=1 -> 4 words at pc 0x010..0x013 on 4 consecutive cycles; done 1 cycle after the END handshake; err_wrap=0.
- Same program, instr_ready held 0 for 10 cycles -> exactly FIFO_DEPTH=4 reads issued, no further mem_rd_en, no word lost or duplicated after ready rises.
- base_pc=0x3FE (ADDR_W=10), no END in memory -> reads 0x3FE and 0x3FF only; err_wrap=1; done after both words are consumed; no read of 0x000.
- abort asserted 3 cycles after start with 2 words buffered -> instr_valid=0 next cycle, busy=0, no done. A new start then refetches from the new base_pc cleanly.
- start pulsed while busy, and start+abort in the same cycle -> both ignored: PC unchanged, fetch continues or stays IDLE respectively.
- With UCODE_FETCH_NOP_SKIP_EN: program NOP, NOP, GEMM, END -> decoder sees only GEMM (pc+2) and END (pc+3); without the macro, all 4 words are seen.

Source files
------------

// File: rtl/ucode_fetch_pkg.sv
// Shared types for the microcode fetch stage: ISA opcode/width constants and fetch FSM states.
package ucode_fetch_pkg;

    localparam int UCODE_ADDR_W = 10;
    localparam int ISA_INSTR_W  = 128;

    typedef enum logic [7:0] {
        OP_NOP  = 8'd0,
        OP_GEMM = 8'd1,
        OP_VEC  = 8'd2,
        OP_END  = 8'd255
    } isa_opcode_e;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_DRAIN = 2'd2,
        FS_DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ucode_fetch_fifo.sv
// Prefetch FIFO with flop storage and registered head; supports push and pop in the same cycle.
module ucode_fetch_fifo #(
    parameter int WIDTH = 138,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign do_push_s = push && (count_q != DEPTH_C);
    assign do_pop_s  = pop && (count_q != '0);

    // Next-state for storage, pointers and occupancy; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign count      = count_q;
    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);

    ucode_fetch_fifo_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push && !flush),
        .full (full)
    );

endmodule

// File: rtl/ucode_fetch_fifo_chk.sv
// Simulation checker for the prefetch FIFO: a push into a full FIFO is a design error.
module ucode_fetch_fifo_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic full
);

    // The fetch credit scheme must never let a word arrive with no free slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/ucode_fetch.sv
// Microcode fetch stage: streams SRAM words from base_pc into a prefetch FIFO until OP_END.
// Optional build macro UCODE_FETCH_NOP_SKIP_EN drops OP_NOP words instead of forwarding them.
module ucode_fetch
    import ucode_fetch_pkg::*;
#(
    parameter int ADDR_W     = UCODE_ADDR_W,
    parameter int FIFO_DEPTH = 4,
    parameter int INSTR_W    = ISA_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_pc,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err_wrap,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [INSTR_W-1:0] mem_rd_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, rd_addr_q, rd_addr_d, ret_addr_q, ret_addr_d;
    logic              rd_en_q, rd_en_d, ret_valid_q, ret_valid_d, last_q, last_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              is_end_s, stop_s, push_s, pop_s, drained_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [CNT_W:0]    credit_s;
    logic              fifo_full_s, fifo_empty_s, fifo_valid_s;
    logic [INSTR_W+ADDR_W-1:0] fifo_head_s;

    // ret_valid_q marks the cycle mem_rd_data carries a word we still intend to keep.
    assign is_end_s = ret_valid_q && (mem_rd_data[7:0] == OP_END);
    assign stop_s   = (state_q == FS_FETCH) && ret_valid_q && (is_end_s || (ret_addr_q == LAST_ADDR));
    assign pop_s    = fifo_valid_s && instr_ready && !abort;
    assign credit_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, rd_en_q} + {{CNT_W{1'b0}}, ret_valid_q};

`ifdef UCODE_FETCH_NOP_SKIP_EN
    logic is_nop_s;
    assign is_nop_s = (mem_rd_data[7:0] == OP_NOP);
    assign push_s   = ret_valid_q && !is_nop_s && !abort;
`else
    assign push_s   = ret_valid_q && !abort;
`endif

    // Finishing when the last buffered word leaves this cycle lets done land right after that handshake.
    assign drained_s = !ret_valid_q && !rd_en_q &&
                       (fifo_empty_s || ((fifo_count_s == CNT_W'(1)) && pop_s));

    // Fetch control: FSM transitions, read issue with credit, and stop detection.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        ret_valid_d = rd_en_q;
        ret_addr_d  = rd_addr_q;
        last_d      = last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        if (abort) begin
            state_d     = FS_IDLE;
            ret_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (start) begin
                        state_d   = FS_FETCH;
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_pc;
                        pc_d      = base_pc + ADDR_W'(1);
                        last_d    = (base_pc == LAST_ADDR);
                        err_d     = 1'b0;
                        busy_d    = 1'b1;
                    end else begin
                        state_d = FS_IDLE;
                    end
                end
                FS_FETCH: begin
                    if (stop_s) begin
                        state_d     = FS_DRAIN;
                        ret_valid_d = 1'b0;
                        err_d       = err_q || !is_end_s;
                    end else if (!last_q && !fifo_full_s && (credit_s < (CNT_W+1)'(FIFO_DEPTH))) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = pc_q;
                        pc_d      = pc_q + ADDR_W'(1);
                        last_d    = (pc_q == LAST_ADDR);
                    end else begin
                        rd_en_d = 1'b0;
                    end
                end
                FS_DRAIN: begin
                    if (drained_s) begin
                        state_d = FS_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = FS_DRAIN;
                    end
                end
                FS_DONE: state_d = FS_IDLE;
                default: state_d = FS_IDLE;
            endcase
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FS_IDLE;
            pc_q        <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            ret_valid_q <= 1'b0;
            ret_addr_q  <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            ret_valid_q <= ret_valid_d;
            ret_addr_q  <= ret_addr_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    ucode_fetch_fifo #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (abort),
        .push       (push_s),
        .push_data  ({mem_rd_data, ret_addr_q}),
        .pop        (pop_s),
        .head_data  (fifo_head_s),
        .head_valid (fifo_valid_s),
        .count      (fifo_count_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign err_wrap    = err_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign instr_valid = fifo_valid_s;
    assign instr_data  = fifo_head_s[INSTR_W+ADDR_W-1:ADDR_W];
    assign instr_pc    = fifo_head_s[ADDR_W-1:0];

endmodule

// File: tb/tb_ucode_fetch.sv
// Directed self-checking bench for ucode_fetch with a one-cycle-latency SRAM model.
module tb_ucode_fetch;
    import ucode_fetch_pkg::*;

    localparam int AW = 10;
    localparam int IW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          instr_ready = 1'b0;
    logic [AW-1:0] base_pc = '0;
    logic          busy, done, err_wrap, mem_rd_en, instr_valid;
    logic [AW-1:0] mem_rd_addr, instr_pc;
    logic [IW-1:0] mem_rd_data, instr_data;

    always #5 clk = ~clk;

    ucode_fetch #(.ADDR_W(AW), .FIFO_DEPTH(4), .INSTR_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_pc(base_pc), .abort(abort),
        .busy(busy), .done(done), .err_wrap(err_wrap),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc)
    );

    logic [IW-1:0] mem [1024];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] hs_pc [$];
    logic [IW-1:0] hs_data [$];
    int            hs_cyc [$];
    logic [AW-1:0] rd_log [$];
    int            done_cnt = 0;
    int            done_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid && instr_ready) begin
                hs_pc.push_back(instr_pc);
                hs_data.push_back(instr_data);
                hs_cyc.push_back(cyc);
            end
            if (mem_rd_en) rd_log.push_back(mem_rd_addr);
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    function automatic logic [IW-1:0] word(input logic [AW-1:0] a, input logic [7:0] op);
        return {{11{a}}, 10'h2A5, op};
    endfunction

    task automatic init_mem();
        for (int a = 0; a < 1024; a++) mem[a] = word(AW'(a), OP_GEMM);
    endtask

    task automatic set_word(input logic [AW-1:0] a, input logic [7:0] op);
        mem[a] = word(a, op);
    endtask

    task automatic pulse_start(input logic [AW-1:0] pc, output int s);
        base_pc = pc;
        start = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err_wrap !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_wrap); end
        checks++; if (mem_rd_en !== 1'b0 || mem_rd_addr !== 10'h000) begin errors++; $display("FAIL reset_rd: got en=%b addr=%0h want 0/0", mem_rd_en, mem_rd_addr); end
        checks++; if (instr_valid !== 1'b0 || instr_pc !== 10'h000) begin errors++; $display("FAIL reset_head: got v=%b pc=%0h want 0/0", instr_valid, instr_pc); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int h0, d0, s, n;
        bit ok;
        logic [7:0] ops [4];
        logic [AW-1:0] ep;
        ops[0] = OP_GEMM; ops[1] = OP_GEMM; ops[2] = OP_VEC; ops[3] = OP_END;
        init_mem();
        for (int i = 0; i < 4; i++) set_word(10'h010 + AW'(i), ops[i]);
        instr_ready = 1'b1;
        h0 = hs_pc.size(); d0 = done_cnt;
        pulse_start(10'h010, s);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_done(d0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no done want done"); end
        n = hs_pc.size() - h0;
        checks++; if (n != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", n); end
        for (int i = 0; i < n && i < 4; i++) begin
            ep = 10'h010 + AW'(i);
            checks++;
            if (hs_pc[h0+i] !== ep || hs_data[h0+i] !== word(ep, ops[i]) || hs_cyc[h0+i] != s + 2 + i) begin
                errors++;
                $display("FAIL basic_word%0d: got pc=%0h cyc=%0d want pc=%0h cyc=%0d", i, hs_pc[h0+i], hs_cyc[h0+i], ep, s + 2 + i);
            end
        end
        checks++; if (done_cyc != s + 6) begin errors++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, s + 6); end
        checks++; if (err_wrap !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_end_flags: got err=%b busy=%b want 0/0", err_wrap, busy); end
    endtask

    task automatic test_backpressure();
        int h0, r0, d0, s, n;
        bit ok;
        init_mem();
        set_word(10'h043, OP_END);
        instr_ready = 1'b0;
        h0 = hs_pc.size(); r0 = rd_log.size(); d0 = done_cnt;
        pulse_start(10'h040, s);
        repeat (10) @(posedge clk);
        #1;
        n = rd_log.size() - r0;
        checks++; if (n != 4) begin errors++; $display("FAIL bp_reads: got %0d want 4", n); end
        for (int i = 0; i < n && i < 4; i++) begin
            checks++;
            if (rd_log[r0+i] !== 10'h040 + AW'(i)) begin errors++; $display("FAIL bp_rd_addr%0d: got %0h want %0h", i, rd_log[r0+i], 10'h040 + AW'(i)); end
        end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'h040 || instr_data !== word(10'h040, OP_GEMM)) begin errors++; $display("FAIL bp_head: got v=%b pc=%0h want 1/40", instr_valid, instr_pc); end
        instr_ready = 1'b1;
        wait_done(d0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no done want done"); end
        n = hs_pc.size() - h0;
        checks++; if (n != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", n); end
        for (int i = 0; i < n && i < 4; i++) begin
            checks++;
            if (hs_pc[h0+i] !== 10'h040 + AW'(i)) begin errors++; $display("FAIL bp_pc%0d: got %0h want %0h", i, hs_pc[h0+i], 10'h040 + AW'(i)); end
        end
    endtask

    task automatic test_wrap();
        int h0, r0, d0, s, n;
        bit ok;
        init_mem();
        instr_ready = 1'b1;
        h0 = hs_pc.size(); r0 = rd_log.size(); d0 = done_cnt;
        pulse_start(10'h3FE, s);
        wait_done(d0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got no done want done"); end
        repeat (4) @(posedge clk);
        #1;
        n = rd_log.size() - r0;
        checks++; if (n != 2) begin errors++; $display("FAIL wrap_reads: got %0d want 2", n); end
        checks++; if (n >= 2 && (rd_log[r0] !== 10'h3FE || rd_log[r0+1] !== 10'h3FF)) begin errors++; $display("FAIL wrap_rd_addr: got %0h,%0h want 3fe,3ff", rd_log[r0], rd_log[r0+1]); end
        checks++; if (err_wrap !== 1'b1) begin errors++; $display("FAIL wrap_err: got %b want 1", err_wrap); end
        n = hs_pc.size() - h0;
        checks++; if (n != 2) begin errors++; $display("FAIL wrap_count: got %0d want 2", n); end
        checks++; if (n >= 2 && done_cyc != hs_cyc[h0+1] + 1) begin errors++; $display("FAIL wrap_done_cyc: got %0d want %0d", done_cyc, hs_cyc[h0+1] + 1); end
    endtask

    task automatic test_abort();
        int h0, d0, s, n;
        bit ok;
        init_mem();
        set_word(10'h086, OP_END);
        set_word(10'h102, OP_END);
        instr_ready = 1'b0;
        d0 = done_cnt;
        pulse_start(10'h080, s);
        checks++; if (err_wrap !== 1'b0) begin errors++; $display("FAIL abort_err_clear: got %b want 0", err_wrap); end
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_flush: got v=%b busy=%b want 0/0", instr_valid, busy); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (done_cnt != d0 || instr_valid !== 1'b0 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL abort_quiet: got done=%0d v=%b en=%b want %0d/0/0", done_cnt, instr_valid, mem_rd_en, d0); end
        instr_ready = 1'b1;
        h0 = hs_pc.size();
        pulse_start(10'h100, s);
        wait_done(d0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_restart_timeout: got no done want done"); end
        n = hs_pc.size() - h0;
        checks++; if (n != 3) begin errors++; $display("FAIL abort_restart_count: got %0d want 3", n); end
        for (int i = 0; i < n && i < 3; i++) begin
            checks++;
            if (hs_pc[h0+i] !== 10'h100 + AW'(i) || hs_cyc[h0+i] != s + 2 + i) begin errors++; $display("FAIL abort_restart_pc%0d: got %0h want %0h", i, hs_pc[h0+i], 10'h100 + AW'(i)); end
        end
    endtask

    task automatic test_start_ignored();
        int h0, r0, d0, s, s2, n, hi;
        bit ok;
        init_mem();
        set_word(10'h203, OP_END);
        instr_ready = 1'b1;
        h0 = hs_pc.size(); r0 = rd_log.size(); d0 = done_cnt;
        pulse_start(10'h200, s);
        pulse_start(10'h300, s2);
        wait_done(d0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_start_timeout: got no done want done"); end
        n = hs_pc.size() - h0;
        checks++; if (n != 4) begin errors++; $display("FAIL busy_start_count: got %0d want 4", n); end
        for (int i = 0; i < n && i < 4; i++) begin
            checks++;
            if (hs_pc[h0+i] !== 10'h200 + AW'(i)) begin errors++; $display("FAIL busy_start_pc%0d: got %0h want %0h", i, hs_pc[h0+i], 10'h200 + AW'(i)); end
        end
        hi = 0;
        for (int i = r0; i < rd_log.size(); i++) if (rd_log[i] >= 10'h300) hi++;
        checks++; if (hi != 0) begin errors++; $display("FAIL busy_start_reads: got %0d reads at 300+ want 0", hi); end
        h0 = hs_pc.size(); r0 = rd_log.size();
        base_pc = 10'h300; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || rd_log.size() != r0 || hs_pc.size() != h0) begin errors++; $display("FAIL start_abort: got busy=%b reads=%0d want 0/0", busy, rd_log.size() - r0); end
    endtask

    task automatic test_nop();
        int h0, d0, s, n, n_exp, first;
        bit ok;
        init_mem();
        set_word(10'h050, OP_NOP);
        set_word(10'h051, OP_NOP);
        set_word(10'h053, OP_END);
`ifdef UCODE_FETCH_NOP_SKIP_EN
        n_exp = 2; first = 2;
`else
        n_exp = 4; first = 0;
`endif
        instr_ready = 1'b1;
        h0 = hs_pc.size(); d0 = done_cnt;
        pulse_start(10'h050, s);
        wait_done(d0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nop_timeout: got no done want done"); end
        n = hs_pc.size() - h0;
        checks++; if (n != n_exp) begin errors++; $display("FAIL nop_count: got %0d want %0d", n, n_exp); end
        for (int i = 0; i < n && i < n_exp; i++) begin
            checks++;
            if (hs_pc[h0+i] !== 10'h050 + AW'(first + i) || hs_data[h0+i] !== mem[10'h050 + AW'(first + i)]) begin
                errors++; $display("FAIL nop_word%0d: got pc=%0h want %0h", i, hs_pc[h0+i], 10'h050 + AW'(first + i));
            end
        end
    endtask

    task automatic test_async_reset();
        int s;
        init_mem();
        instr_ready = 1'b0;
        pulse_start(10'h010, s);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || instr_valid !== 1'b0 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL async_rst: got busy=%b v=%b en=%b want 0/0/0", busy, instr_valid, mem_rd_en); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_rst_after: got v=%b busy=%b want 0/0", instr_valid, busy); end
    endtask

    initial begin
        init_mem();
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_abort();
        test_start_ignored();
        test_nop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
